line_stream_buffer: RTL and testbench

- Parametrised, double-buffered line store between the per-line fractal engine and the pixel packer.
- The engine fills one bank with per-pixel iteration depths while the other bank is colour-mapped and streamed out with a valid/ready handshake.
- Engine compute for line N+1 overlaps streaming of line N.
- Adds selectable colour mode, inversion, frame/line markers and full stall tolerance.

---
 rtl/line_stream_buffer.sv | 225 ++++++++++++++++++++++
 tb/tb_line_stream_buffer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_stream_buffer.sv
// Double-buffered line store: the engine fills one bank with iteration depths
// while the other bank is colour-mapped and streamed out over valid/ready.
module line_stream_buffer #(
  parameter int X_SIZE       = 640,
  parameter int Y_SIZE       = 480,
  parameter int DEPTH_W      = 10,
  parameter int MAX_ITER_LOG = 8,
  parameter int AW           = $clog2(X_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        eng_start,
  input  logic                        eng_done,
  input  logic                        eng_we,
  input  logic [AW-1:0]               eng_addr,
  input  logic [DEPTH_W-1:0]          eng_depth,
  input  logic                        cfg_mode,
  input  logic                        cfg_invert,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_r,
  output logic [7:0]                  out_g,
  output logic [7:0]                  out_b,
  output logic [$clog2(X_SIZE)-1:0]   out_x,
  output logic [$clog2(Y_SIZE)-1:0]   out_y,
  output logic                        out_sof,
  output logic                        out_eol
);

  localparam int XW       = $clog2(X_SIZE);
  localparam int YW       = $clog2(Y_SIZE);
  localparam int MAX_ITER = 1 << MAX_ITER_LOG;
  localparam int SHR      = (MAX_ITER_LOG >= 8) ? (MAX_ITER_LOG - 8) : 0;
  localparam int SHL      = (MAX_ITER_LOG < 8) ? (8 - MAX_ITER_LOG) : 0;

  localparam logic [XW:0]   X_ONE = 1;
  localparam logic [XW:0]   X_TWO = 2;
  localparam logic [XW-1:0] X_INC = 1;
  localparam logic [YW-1:0] Y_INC = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } drain_state_t;

  // Depth to RGB: scale to 8 bits, saturate at MAX_ITER, optional invert.
  function automatic logic [23:0] map_colour(input logic [DEPTH_W-1:0] d,
                                             input logic mode,
                                             input logic inv);
    logic [7:0] norm;
    logic [7:0] i;
    if (32'(d) >= MAX_ITER) begin
      norm = 8'd255;
    end else begin
      norm = 8'((({8'd0, d}) >> SHR) << SHL);
    end
    i = inv ? (8'd255 - norm) : norm;
    if (mode) begin
      return {i, {1'b0, i[7:1]}, 8'd255 - i};
    end else begin
      return {i, i, i};
    end
  endfunction

  logic [DEPTH_W-1:0] bank0 [X_SIZE];
  logic [DEPTH_W-1:0] bank1 [X_SIZE];

  logic [1:0]         full;
  logic               fill_sel;
  logic               drain_sel;
  logic               outstanding;
  logic               start_cond;
  logic               done_ok;

  drain_state_t       state;
  drain_state_t       state_next;
  logic               rd_req;
  logic               rd_en;
  logic [XW:0]        rd_addr;
  logic [DEPTH_W-1:0] rd_q;
  logic               handshake;
  logic               load;
  logic [XW-1:0]      load_x;
  logic               drop;

  assign start_cond = !outstanding && !full[fill_sel];
  assign done_ok    = eng_done && outstanding;
  assign handshake  = out_valid && out_ready;
  assign rd_en      = rd_req && (32'(rd_addr) < X_SIZE);

  // Fill-side control: line request pulse, outstanding flag, fill bank pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_start   <= 1'b0;
      outstanding <= 1'b0;
      fill_sel    <= 1'b0;
    end else begin
      eng_start <= start_cond;
      if (start_cond) begin
        outstanding <= 1'b1;
      end else if (done_ok) begin
        outstanding <= 1'b0;
        fill_sel    <= ~fill_sel;
      end
    end
  end

  // Bank full flags: set by the fill side, cleared by the drain side (never the same bank).
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      if (done_ok) begin
        full[fill_sel] <= 1'b1;
      end
      if (drop) begin
        full[drain_sel] <= 1'b0;
      end
    end
  end

  // Engine writes land only in the bank being filled and only for in-range x.
  always_ff @(posedge clk) begin
    if (eng_we && outstanding && (32'(eng_addr) < X_SIZE)) begin
      if (fill_sel) begin
        bank1[eng_addr] <= eng_depth;
      end else begin
        bank0[eng_addr] <= eng_depth;
      end
    end
  end

  // Synchronous read of the draining bank.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_q <= drain_sel ? bank1[rd_addr[XW-1:0]] : bank0[rd_addr[XW-1:0]];
    end
  end

  // Drain state register and drain bank pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_sel <= 1'b0;
    end else begin
      state <= state_next;
      if (drop) begin
        drain_sel <= ~drain_sel;
      end
    end
  end

  // Drain next-state; rd_q always holds the pixel after the one presented, so a
  // handshake loads rd_q and reads one further ahead, while a stall re-reads.
  always_comb begin
    state_next = state;
    rd_req     = 1'b0;
    rd_addr    = '0;
    load       = 1'b0;
    load_x     = '0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (full[drain_sel]) begin
          state_next = PRIME;
          rd_req     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      PRIME: begin
        load       = 1'b1;
        rd_req     = 1'b1;
        rd_addr    = X_ONE;
        state_next = STREAM;
      end
      STREAM: begin
        if (handshake) begin
          if (out_eol) begin
            drop       = 1'b1;
            state_next = IDLE;
          end else begin
            load    = 1'b1;
            load_x  = out_x + X_INC;
            rd_req  = 1'b1;
            rd_addr = {1'b0, out_x} + X_TWO;
          end
        end else begin
          rd_req  = 1'b1;
          rd_addr = {1'b0, out_x} + X_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output register: loaded per pixel with cfg sampled here; held during stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_r     <= 8'd0;
      out_g     <= 8'd0;
      out_b     <= 8'd0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (load) begin
      out_valid               <= 1'b1;
      out_x                   <= load_x;
      {out_r, out_g, out_b}   <= map_colour(rd_q, cfg_mode, cfg_invert);
      out_sof                 <= (load_x == '0) && (out_y == '0);
      out_eol                 <= (32'(load_x) == X_SIZE - 1);
    end else if (drop) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_y     <= (32'(out_y) == Y_SIZE - 1) ? '0 : out_y + Y_INC;
    end
  end

endmodule

// File: tb/tb_line_stream_buffer.sv
// Directed bench for line_stream_buffer: an 8x2 instance with a small engine
// model, plus a 6x2 instance with MAX_ITER_LOG=6 driven by hand.
module tb_line_stream_buffer;
  localparam int X = 8;
  localparam int Y = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, eng_start, eng_done, eng_we, cfg_mode, cfg_invert;
  logic [2:0] eng_addr;
  logic [9:0] eng_depth;
  logic       out_valid, out_ready, out_sof, out_eol;
  logic [7:0] out_r, out_g, out_b;
  logic [2:0] out_x;
  logic [0:0] out_y;

  logic       r2, e2_start, e2_done, e2_we, o2_valid, ready2, o2_sof, o2_eol;
  logic [2:0] e2_addr, o2_x;
  logic [9:0] e2_depth;
  logic [7:0] o2_r, o2_g, o2_b;
  logic [0:0] o2_y;

  line_stream_buffer #(.X_SIZE(X), .Y_SIZE(Y), .DEPTH_W(10), .MAX_ITER_LOG(8)) dut (
    .clk(clk), .reset(reset), .eng_start(eng_start), .eng_done(eng_done),
    .eng_we(eng_we), .eng_addr(eng_addr), .eng_depth(eng_depth),
    .cfg_mode(cfg_mode), .cfg_invert(cfg_invert), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol));

  line_stream_buffer #(.X_SIZE(6), .Y_SIZE(2), .DEPTH_W(10), .MAX_ITER_LOG(6)) dut2 (
    .clk(clk), .reset(r2), .eng_start(e2_start), .eng_done(e2_done),
    .eng_we(e2_we), .eng_addr(e2_addr), .eng_depth(e2_depth),
    .cfg_mode(1'b0), .cfg_invert(1'b0), .out_valid(o2_valid),
    .out_ready(ready2), .out_r(o2_r), .out_g(o2_g), .out_b(o2_b),
    .out_x(o2_x), .out_y(o2_y), .out_sof(o2_sof), .out_eol(o2_eol));

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;

  logic       eng_en;
  logic [9:0] depth_tab [X];
  logic       man_we, man_done;
  logic [2:0] man_addr;
  logic [9:0] man_depth;

  logic [2:0]  px_x   [32];
  logic        px_y   [32];
  logic [23:0] px_rgb [32];
  logic        px_sof [32];
  logic        px_eol [32];
  int          px_cyc [32];
  int          got;
  int          stall_bad;

  // Engine model: answers eng_start with one write per cycle, eng_done with the last.
  initial begin
    int pos;
    bit busy;
    busy = 0; pos = 0;
    eng_we = 1'b0; eng_done = 1'b0; eng_addr = 3'd0; eng_depth = 10'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0; eng_we = 1'b0; eng_done = 1'b0;
      end else if (busy) begin
        eng_we = 1'b1; eng_addr = 3'(pos); eng_depth = depth_tab[pos];
        eng_done = (pos == X - 1);
        pos++;
        if (pos == X) busy = 0;
      end else begin
        eng_we = man_we; eng_addr = man_addr; eng_depth = man_depth; eng_done = man_done;
        if (eng_en && eng_start) begin
          busy = 1; pos = 0;
        end
      end
    end
  end

  // eng_start pulse counter.
  initial forever begin
    @(negedge clk);
    if (eng_start) start_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; out_ready = 1'b0;
    tick; tick; tick;
    reset = 1'b0;
  endtask

  task automatic set_ramp;
    for (int i = 0; i < X; i++) depth_tab[i] = 10'(i);
  endtask

  task automatic collect(input int n, input bit rnd);
    int cyc;
    bit held, rdy;
    logic [30:0] snap, cur;
    got = 0; stall_bad = 0; held = 0; cyc = 0; snap = '0;
    while (got < n && cyc < 2000) begin
      cur = {out_valid, out_x, out_y, out_r, out_g, out_b, out_sof, out_eol};
      if (held && cur !== snap) stall_bad++;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (out_valid && rdy) begin
        px_x[got] = out_x; px_y[got] = out_y[0]; px_rgb[got] = {out_r, out_g, out_b};
        px_sof[got] = out_sof; px_eol[got] = out_eol; px_cyc[got] = cyc;
        got++;
      end
      held = out_valid && !rdy;
      snap = cur;
      tick;
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; out_ready = 1'b0; eng_en = 1'b1;
    tick; tick; tick;
    n_cmp++;
    if ({out_valid, eng_start, out_sof, out_eol} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0000", {out_valid, eng_start, out_sof, out_eol});
    end
    n_cmp++;
    if ({out_x, out_y, out_r, out_g, out_b} !== 28'd0) begin
      n_bad++; $display("FAIL reset_data: got %h expected 0", {out_x, out_y, out_r, out_g, out_b});
    end
    reset = 1'b0;
    tick;
    n_cmp++;
    if (eng_start !== 1'b1) begin
      n_bad++; $display("FAIL first_start: got %b expected 1", eng_start);
    end
    tick;
    n_cmp++;
    if (eng_start !== 1'b0) begin
      n_bad++; $display("FAIL start_single_pulse: got %b expected 0", eng_start);
    end
  endtask

  task automatic test_stream;
    logic [29:0] act, exp_t;
    int x;
    collect(24, 1'b0);
    n_cmp++;
    if (got !== 24) begin
      n_bad++; $display("FAIL stream_count: got %0d expected 24", got);
    end
    for (int i = 0; i < got; i++) begin
      x = i % X;
      act   = {px_x[i], px_y[i], px_rgb[i], px_sof[i], px_eol[i]};
      exp_t = {3'(x), 1'((i / X) % Y), {3{8'(x)}}, (i % (X * Y)) == 0, x == X - 1};
      n_cmp++;
      if (act !== exp_t) begin
        n_bad++; $display("FAIL stream_pixel[%0d]: got %h expected %h", i, act, exp_t);
      end
      if (x != 0) begin
        n_cmp++;
        if (px_cyc[i] - px_cyc[i-1] !== 1) begin
          n_bad++; $display("FAIL stream_rate[%0d]: gap %0d expected 1", i, px_cyc[i] - px_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_colour;
    logic [7:0] inv_i [8] = '{8'd0, 8'd0, 8'd255, 8'd250, 8'd0, 8'd127, 8'd191, 8'd248};
    logic [7:0] m1_r  [8] = '{8'd255, 8'd255, 8'd0, 8'd5, 8'd255, 8'd128, 8'd64, 8'd7};
    logic [7:0] m1_g  [8] = '{8'd127, 8'd127, 8'd0, 8'd2, 8'd127, 8'd64, 8'd32, 8'd3};
    logic [7:0] m1_b  [8] = '{8'd0, 8'd0, 8'd255, 8'd250, 8'd0, 8'd127, 8'd191, 8'd248};
    depth_tab = '{10'd256, 10'd300, 10'd0, 10'd5, 10'd255, 10'd128, 10'd64, 10'd7};
    cfg_mode = 1'b0; cfg_invert = 1'b1;
    apply_reset;
    collect(8, 1'b0);
    n_cmp++;
    if (got !== 8) begin
      n_bad++; $display("FAIL invert_count: got %0d expected 8", got);
    end
    for (int i = 0; i < got; i++) begin
      n_cmp++;
      if (px_rgb[i] !== {3{inv_i[i]}}) begin
        n_bad++; $display("FAIL invert_rgb[%0d]: got %h expected %h", i, px_rgb[i], {3{inv_i[i]}});
      end
    end
    cfg_mode = 1'b1; cfg_invert = 1'b0;
    apply_reset;
    collect(8, 1'b0);
    n_cmp++;
    if (got !== 8) begin
      n_bad++; $display("FAIL ramp_count: got %0d expected 8", got);
    end
    for (int i = 0; i < got; i++) begin
      n_cmp++;
      if (px_rgb[i] !== {m1_r[i], m1_g[i], m1_b[i]}) begin
        n_bad++; $display("FAIL ramp_rgb[%0d]: got %h expected %h", i, px_rgb[i], {m1_r[i], m1_g[i], m1_b[i]});
      end
    end
    cfg_mode = 1'b0; cfg_invert = 1'b0;
  endtask

  task automatic test_stall;
    logic [29:0] act, exp_t;
    int x;
    set_ramp;
    apply_reset;
    collect(24, 1'b1);
    n_cmp++;
    if (got !== 24) begin
      n_bad++; $display("FAIL stall_count: got %0d expected 24", got);
    end
    n_cmp++;
    if (stall_bad !== 0) begin
      n_bad++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", stall_bad);
    end
    for (int i = 0; i < got; i++) begin
      x = i % X;
      act   = {px_x[i], px_y[i], px_rgb[i], px_sof[i], px_eol[i]};
      exp_t = {3'(x), 1'((i / X) % Y), {3{8'(x)}}, (i % (X * Y)) == 0, x == X - 1};
      n_cmp++;
      if (act !== exp_t) begin
        n_bad++; $display("FAIL stall_pixel[%0d]: got %h expected %h", i, act, exp_t);
      end
    end
  endtask

  task automatic test_back_pressure;
    int base, c;
    set_ramp;
    apply_reset;
    base = start_cnt;
    repeat (60) tick;
    n_cmp++;
    if (start_cnt - base !== 2) begin
      n_bad++; $display("FAIL bp_starts: got %0d expected 2", start_cnt - base);
    end
    n_cmp++;
    if ({out_valid, out_x} !== 4'b1000) begin
      n_bad++; $display("FAIL bp_hold: got %b expected 1000", {out_valid, out_x});
    end
    out_ready = 1'b1;
    c = 0;
    while (!(out_valid && out_eol) && c < 40) begin
      tick; c++;
    end
    n_cmp++;
    if (c >= 40) begin
      n_bad++; $display("FAIL bp_eol_timeout: got %0d cycles expected under 40", c);
    end
    tick;
    n_cmp++;
    if (eng_start !== 1'b0) begin
      n_bad++; $display("FAIL bp_start_early: got %b expected 0", eng_start);
    end
    tick;
    n_cmp++;
    if (eng_start !== 1'b1) begin
      n_bad++; $display("FAIL bp_resume: got %b expected 1", eng_start);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_spurious;
    int base;
    set_ramp;
    apply_reset;
    repeat (40) tick;
    eng_en = 1'b0;
    base = start_cnt;
    man_we = 1'b1; man_addr = 3'd2; man_depth = 10'd999; man_done = 1'b1;
    tick;
    man_we = 1'b0; man_done = 1'b0;
    repeat (5) tick;
    n_cmp++;
    if (start_cnt - base !== 0) begin
      n_bad++; $display("FAIL spurious_start: got %0d expected 0", start_cnt - base);
    end
    collect(16, 1'b0);
    n_cmp++;
    if (got !== 16) begin
      n_bad++; $display("FAIL spurious_count: got %0d expected 16", got);
    end
    for (int i = 0; i < got; i++) begin
      n_cmp++;
      if ({px_y[i], px_rgb[i]} !== {1'(i / X), {3{8'(i % X)}}}) begin
        n_bad++; $display("FAIL spurious_data[%0d]: got %h expected %h", i, {px_y[i], px_rgb[i]}, {1'(i / X), {3{8'(i % X)}}});
      end
    end
    eng_en = 1'b1;
  endtask

  task automatic test_reset_midstream;
    int c;
    set_ramp;
    apply_reset;
    out_ready = 1'b1;
    c = 0;
    while (!(out_valid && out_x == 3'd3) && c < 60) begin
      tick; c++;
    end
    n_cmp++;
    if (c >= 60) begin
      n_bad++; $display("FAIL mid_reach_x3: got %0d cycles expected under 60", c);
    end
    reset = 1'b1;
    tick;
    n_cmp++;
    if ({out_valid, out_x, out_y} !== 5'd0) begin
      n_bad++; $display("FAIL mid_reset_out: got %b expected 00000", {out_valid, out_x, out_y});
    end
    tick; tick;
    reset = 1'b0; out_ready = 1'b0;
    tick;
    n_cmp++;
    if (eng_start !== 1'b1) begin
      n_bad++; $display("FAIL mid_restart: got %b expected 1", eng_start);
    end
    collect(1, 1'b0);
    n_cmp++;
    if ({got[0], px_x[0], px_y[0], px_sof[0], px_rgb[0]} !== {1'b1, 3'd0, 1'b0, 1'b1, 24'd0}) begin
      n_bad++; $display("FAIL mid_first_pixel: got %h expected %h",
                        {got[0], px_x[0], px_y[0], px_sof[0], px_rgb[0]}, {1'b1, 3'd0, 1'b0, 1'b1, 24'd0});
    end
  endtask

  task automatic test_small_iter;
    logic [9:0] tab [6] = '{10'd10, 10'd64, 10'd0, 10'd1, 10'd63, 10'd20};
    logic [7:0] exp_i [6] = '{8'd40, 8'd255, 8'd0, 8'd4, 8'd252, 8'd80};
    logic [23:0] rgb2 [6];
    logic eol2 [6];
    int got2;
    r2 = 1'b1; ready2 = 1'b0; e2_we = 1'b0; e2_done = 1'b0; e2_addr = 3'd0; e2_depth = 10'd0;
    tick; tick;
    r2 = 1'b0;
    tick;
    n_cmp++;
    if (e2_start !== 1'b1) begin
      n_bad++; $display("FAIL small_start: got %b expected 1", e2_start);
    end
    for (int k = 0; k < 8; k++) begin
      e2_we = 1'b1; e2_addr = 3'(k);
      e2_depth = (k < 6) ? tab[k] : 10'd999;
      e2_done = (k == 7);
      tick;
    end
    e2_we = 1'b0; e2_done = 1'b0;
    ready2 = 1'b1;
    got2 = 0;
    for (int c = 0; c < 30 && got2 < 6; c++) begin
      if (o2_valid) begin
        rgb2[got2] = {o2_r, o2_g, o2_b}; eol2[got2] = o2_eol; got2++;
      end
      tick;
    end
    ready2 = 1'b0;
    n_cmp++;
    if (got2 !== 6) begin
      n_bad++; $display("FAIL small_count: got %0d expected 6", got2);
    end
    for (int i = 0; i < got2; i++) begin
      n_cmp++;
      if ({rgb2[i], eol2[i]} !== {{3{exp_i[i]}}, i == 5}) begin
        n_bad++; $display("FAIL small_rgb[%0d]: got %h expected %h", i, {rgb2[i], eol2[i]}, {{3{exp_i[i]}}, i == 5});
      end
    end
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; cfg_mode = 1'b0; cfg_invert = 1'b0; eng_en = 1'b1;
    man_we = 1'b0; man_done = 1'b0; man_addr = 3'd0; man_depth = 10'd0;
    r2 = 1'b1; ready2 = 1'b0; e2_we = 1'b0; e2_done = 1'b0; e2_addr = 3'd0; e2_depth = 10'd0;
    set_ramp;
    test_reset;
    test_stream;
    test_colour;
    test_stall;
    test_back_pressure;
    test_spurious;
    test_reset_midstream;
    test_small_iter;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
